frame_sync_tx: RTL and testbench
================================

Name: frame_sync_tx

Overview:
- Parametrised UART serializer: emits a configurable sync character once per video frame, aligned to the internal frame generator.
- Also carries host bytes over a valid/ready handshake; a pending sync always wins over host data.
- Adds configurable word length, stop bits, oversample ratio, and missed-sync reporting, none of which the fixed single-character generator provides.
- Sits between the frame timing generator (frame strobe), the shared oversample tick (uart_clk) and the chip serial output pin.

Parameters:
- OVERSAMPLE, 6: uart_clk ticks per serial bit (range 2..16).
- DATA_BITS, 8: data bits per character, sent LSB first (range 5..8).
- STOP_BITS, 1: stop bits, logic 1 (range 1..2).
- SYNC_CHAR, 8'h80: reset value of the sync character (Win1252 Euro). Its width is DATA_BITS.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- enable_frame, input, 1: one-clk frame strobe (60 Hz).
- uart_clk, input, 1: one-clk tick at OVERSAMPLE x baud.
- sync_char, input, DATA_BITS: sync character, sampled when a sync frame is loaded.
- data_in, input, DATA_BITS: host byte.
- data_valid, input, 1: host byte valid.
- data_ready, output, 1: block accepts data_in this cycle (combinational).
- tx, output, 1: serial out; idle is high. Registered.
- busy, output, 1: a character is in flight. Registered.
- sync_miss, output, 1: one-clk pulse when a frame strobe is lost. Registered.

Behaviour:
- Reset (async, rst_n=0) values:
  - tx=1, busy=0, sync_miss=0
  - state=IDLE, sync_pend=0
  - tick counter=0, bit counter=0, shift register=all 1s
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If uart_clk=1 and (sync_pend or enable_frame): load sync_char, clear sync_pend, go to START.
  - Otherwise, if uart_clk=1 and data_valid=1: load data_in, go to START.
- data_ready is (state==IDLE) and uart_clk and !sync_pend and !enable_frame.
  - Transfer occurs only when data_valid and data_ready are both high.
  - data_in may change freely while data_ready=0.
- On entering START:
  - tx=0 and busy=1 from the next clk.
  - tick counter = OVERSAMPLE-1.
- Bit timing:
  - Each uart_clk in a non-IDLE state decrements the tick counter.
  - A uart_clk arriving with tick counter=0 ends the current bit and reloads OVERSAMPLE-1.
- Bit sequence:
  - START -> DATA: tx = shift[0], then shift right once per bit, for DATA_BITS bits.
  - DATA -> STOP: tx=1 for STOP_BITS bits.
  - STOP -> IDLE: busy=0.
- Character length is exactly (1+DATA_BITS+STOP_BITS)*OVERSAMPLE uart_clk ticks; 60 ticks at the defaults.
- Back-to-back: the IDLE state lasts at least until the next uart_clk, so there is no zero-gap chaining; the line stays high for at least one tick.
- Frame strobe while not in IDLE:
  - sync_pend=0: set sync_pend=1.
  - sync_pend=1: sync_miss pulses for 1 clk and sync_pend stays 1 (at most one sync is queued).
- Simultaneous frame strobe and host valid in IDLE on a uart_clk: sync is sent; data is not accepted (data_ready=0).
- Frame strobe in IDLE without uart_clk: sets sync_pend; sync starts on the next uart_clk.
- uart_clk and enable_frame are ignored while rst_n=0.
- rst_n asserted mid-character: tx returns to 1 immediately (async), pending sync is discarded, and there is no partial-character recovery.
- Compatibility: the defaults (0x80, 8N1, x6) produce a low period of exactly 8 bit times (48 ticks), matching the existing frame-sync pulse width.

Decomposition:
- Shared package (uart_pkg) holds:
  - state enumeration: IDLE, START, DATA, STOP
  - state-width constant
  - default constants: OVERSAMPLE_DEF=6, DATA_BITS_DEF=8, EURO_CHAR=8'h80
- One natural sub-module, uart_bit_timer:
  - Parametrised OVERSAMPLE down-counter.
  - Inputs: clk, rst_n, uart_clk, restart.
  - Output: bit_done pulse.
- The FSM, shift register, sync queue and handshake live in frame_sync_tx.

Test Plan:
- Reset with defaults, rst_n low for 3 clk, then release; uart_clk every 4 clk -> tx=1, busy=0, data_ready high only on uart_clk cycles.
- enable_frame pulse, defaults -> tx low for exactly 48 uart_clk ticks, then high for 12; busy=1 for 60 ticks; sync_miss never pulses.
- data_valid=1, data_in=8'hA5, no frame strobe -> accepted on the first uart_clk; tx bits (6 ticks each) are 0, 1,0,1,0,0,1,0,1, 1 (start, LSB-first data, stop).
- enable_frame and data_valid (8'h55) on the same uart_clk cycle -> 8'h80 is sent first and data_ready=0 that cycle; 8'h55 is accepted on the first uart_clk after the sync finishes.
- Two frame strobes during one host character -> first sets sync_pend; second gives a single 1-clk sync_miss; exactly one sync character follows.
- DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=4, sync_char=7'h40 -> frame is 40 ticks; low for 28 ticks; rst_n pulsed mid-DATA drives tx=1 asynchronously and busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the frame-sync UART serializer: FSM state codes and default parameters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // FSM state encoding, kept as plain constants so older tools and scripts can read them.
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_START = 2'd1;
    localparam logic [STATE_W-1:0] ST_DATA  = 2'd2;
    localparam logic [STATE_W-1:0] ST_STOP  = 2'd3;

    // Default line format: 8N1 at 6x oversample, sync character = Win1252 Euro.
    localparam int          OVERSAMPLE_DEF = 6;
    localparam int          DATA_BITS_DEF  = 8;
    localparam int          STOP_BITS_DEF  = 1;
    localparam logic [7:0]  EURO_CHAR      = 8'h80;

    // Counter widths sized for the largest legal parameters (OVERSAMPLE 16, DATA_BITS 8).
    localparam int TICK_W   = 4;
    localparam int BITCNT_W = 3;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts OVERSAMPLE uart_clk ticks per serial bit and flags the tick that ends a bit.
// Latency: bit_done is combinational from the current count and uart_clk; restart takes effect next clk.
// Backpressure: none; free-running on uart_clk, re-aligned by restart.
//
// Ports: clk/rst_n (async active-low), uart_clk (oversample tick), restart (reload at character start),
//        bit_done (high on the uart_clk that closes the current bit).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_clk,
    input  logic restart,
    output logic bit_done
);

    localparam logic [TICK_W-1:0] RELOAD = TICK_W'(OVERSAMPLE - 1);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    assign bit_done = uart_clk && (cnt_q == '0);

    // The counter also runs while the transmitter idles; that is harmless because every
    // character start reloads it, so bit boundaries are always measured from the load tick.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = RELOAD;
        end else if (uart_clk) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_sync_tx.sv
// UART serializer sending one sync character per video frame, plus host bytes in the gaps.
// Latency: load on a uart_clk in IDLE, start bit on tx from the next clk; character = (1+DATA_BITS+STOP_BITS)*OVERSAMPLE ticks.
// Backpressure: data_ready only in IDLE on a uart_clk with no sync due; one sync may queue, a further strobe pulses sync_miss.
//
// Ports: clk, rst_n (async active-low); enable_frame (frame strobe); uart_clk (oversample tick);
//        sync_char / data_in / data_valid / data_ready (host handshake); tx, busy, sync_miss (registered).
module frame_sync_tx
    import uart_pkg::*;
#(
    parameter int          OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int          DATA_BITS  = DATA_BITS_DEF,
    parameter int          STOP_BITS  = STOP_BITS_DEF,
    parameter int unsigned SYNC_CHAR  = 32'(EURO_CHAR)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_frame,
    input  logic                 uart_clk,
    input  logic [DATA_BITS-1:0] sync_char,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 sync_miss
);

    // Reject illegal configurations at elaboration rather than producing a malformed line.
    if (OVERSAMPLE < 2 || OVERSAMPLE > 16) begin : g_bad_oversample
        $error("frame_sync_tx: OVERSAMPLE must be 2..16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("frame_sync_tx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("frame_sync_tx: STOP_BITS must be 1..2");
    end
    if (SYNC_CHAR >= (32'd1 << DATA_BITS)) begin : g_bad_sync_char
        $error("frame_sync_tx: SYNC_CHAR does not fit in DATA_BITS");
    end

    localparam logic [BITCNT_W-1:0] LAST_DATA = BITCNT_W'(DATA_BITS - 1);
    localparam logic [BITCNT_W-1:0] LAST_STOP = BITCNT_W'(STOP_BITS - 1);

    logic [STATE_W-1:0]   state_q,     state_d;
    logic                 sync_pend_q, sync_pend_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [BITCNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic                 tx_q,        tx_d;
    logic                 busy_q,      busy_d;
    logic                 sync_miss_q, sync_miss_d;

    logic idle;
    logic load_sync;
    logic load_data;
    logic bit_done;

    assign idle       = (state_q == ST_IDLE);
    // A due sync (queued or arriving now) always beats host data on the same tick.
    assign load_sync  = idle && uart_clk && (sync_pend_q || enable_frame);
    assign data_ready = idle && uart_clk && !sync_pend_q && !enable_frame;
    assign load_data  = data_ready && data_valid;

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_clk (uart_clk),
        .restart  (load_sync || load_data),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d     = state_q;
        sync_pend_d = sync_pend_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        sync_miss_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_sync) begin
                    shift_d     = sync_char;
                    sync_pend_d = 1'b0;
                    state_d     = ST_START;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                end else if (load_data) begin
                    shift_d = data_in;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else if (enable_frame) begin
                    sync_pend_d = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b1, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                // Each data bit is put on the line when the previous bit ends.
                if (bit_done) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d   = ST_STOP;
                        tx_d      = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b1, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only one sync can be queued behind a character in flight; a second strobe is reported.
        if (!idle && enable_frame) begin
            if (sync_pend_q) begin
                sync_miss_d = 1'b1;
            end else begin
                sync_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sync_pend_q <= 1'b0;
            shift_q     <= '1;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            sync_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_pend_q <= sync_pend_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            sync_miss_q <= sync_miss_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign sync_miss = sync_miss_q;

endmodule

// File: tb/tb_frame_sync_tx.sv
// Bench for frame_sync_tx: default 8N1 x6 instance against a character-level model, plus a 7-bit/2-stop/x4 instance.
// Latency: n/a.
// Backpressure: host valid is held until the model sees the transfer.
module tb_frame_sync_tx;

    localparam int OS         = 6;
    localparam int NB         = 10;         // start + 8 data + 1 stop
    localparam int CHAR_TICKS = OS * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, enable_frame, uart_clk, data_valid;
    logic [7:0] sync_char, data_in;
    logic       data_ready, tx, busy, sync_miss;

    logic       rst2_n, enable_frame2, data_valid2;
    logic [6:0] sync_char2, data_in2;
    logic       data_ready2, tx2, busy2, sync_miss2;

    frame_sync_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_frame (enable_frame),
        .uart_clk     (uart_clk),
        .sync_char    (sync_char),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .tx           (tx),
        .busy         (busy),
        .sync_miss    (sync_miss)
    );

    frame_sync_tx #(
        .OVERSAMPLE (4),
        .DATA_BITS  (7),
        .STOP_BITS  (2),
        .SYNC_CHAR  (32'h40)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst2_n),
        .enable_frame (enable_frame2),
        .uart_clk     (uart_clk),
        .sync_char    (sync_char2),
        .data_in      (data_in2),
        .data_valid   (data_valid2),
        .data_ready   (data_ready2),
        .tx           (tx2),
        .busy         (busy2),
        .sync_miss    (sync_miss2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Character-level reference: a character in flight is a 10-bit line word and the number
    // of ticks elapsed since it was loaded; the line level is the word bit for elapsed/OS.
    bit            m_busy, m_pend, m_miss;
    int            m_elapsed;
    logic [NB-1:0] m_word;

    function automatic logic m_tx();
        return m_busy ? m_word[m_elapsed / OS] : 1'b1;
    endfunction

    task automatic m_load(input logic [7:0] c);
        m_busy    = 1'b1;
        m_elapsed = 0;
        m_word    = {1'b1, c, 1'b0};
    endtask

    int obs_q[$];
    int busy_ticks, low_ticks, miss_cycles;
    int busy2_ticks, low2_ticks, miss2_cycles;

    // One clk: check outputs, apply inputs, check data_ready, advance the model, wait a clk.
    task automatic step(input bit frm, input bit uck, input bit vld, input logic [7:0] din,
                        input logic [7:0] sch, output bit accepted);
        bit exp_rdy;
        check_eq("tx", tx, m_tx());
        check_eq("busy", busy, m_busy);
        check_eq("sync_miss", sync_miss, m_miss);
        if (sync_miss)  miss_cycles++;
        if (sync_miss2) miss2_cycles++;
        if (uck) begin
            obs_q.push_back(int'(tx));
            if (busy)          busy_ticks++;
            if (busy && !tx)   low_ticks++;
            if (busy2)         busy2_ticks++;
            if (busy2 && !tx2) low2_ticks++;
        end
        enable_frame = frm;
        uart_clk     = uck;
        data_valid   = vld;
        data_in      = din;
        sync_char    = sch;
        #1;
        exp_rdy = !m_busy && uck && !m_pend && !frm;
        check_eq("data_ready", data_ready, exp_rdy);
        accepted = exp_rdy && vld;
        m_miss = 1'b0;
        if (m_busy) begin
            if (frm) begin
                if (m_pend) m_miss = 1'b1;
                else        m_pend = 1'b1;
            end
            if (uck) begin
                m_elapsed++;
                if (m_elapsed == CHAR_TICKS) m_busy = 1'b0;
            end
        end else if (uck && (m_pend || frm)) begin
            m_load(sch);
            m_pend = 1'b0;
        end else if (accepted) begin
            m_load(din);
        end else if (frm) begin
            m_pend = 1'b1;
        end
        @(negedge clk);
    endtask

    bit         hv, fr, fr2;
    logic [7:0] hd;
    logic [7:0] sc = 8'h80;

    task automatic cyc(input bit uck);
        bit acc;
        enable_frame2 = fr2;
        step(fr, uck, hv, hd, sc, acc);
        fr  = 1'b0;
        fr2 = 1'b0;
        if (acc) hv = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
        end
    endtask

    function automatic int first_low(input int from);
        for (int i = from; i < obs_q.size(); i++) begin
            if (obs_q[i] == 0) return i;
        end
        return -1;
    endfunction

    // Sample each data bit mid-way through its OS-tick window, starting from the first start-bit tick.
    function automatic logic [7:0] decode_at(input int s);
        logic [7:0] v;
        v = 'x;
        if (s >= 0 && s + CHAR_TICKS <= obs_q.size()) begin
            for (int b = 0; b < 8; b++) v[b] = (obs_q[s + OS * (b + 1) + OS / 2] != 0);
        end
        return v;
    endfunction

    function automatic int count_chars();
        int n = 0;
        int i = 0;
        while (i < obs_q.size()) begin
            if (obs_q[i] == 0) begin
                n++;
                i += CHAR_TICKS;
            end else begin
                i++;
            end
        end
        return n;
    endfunction

    initial begin
        int s1, s2;
        rst_n = 1'b0; rst2_n = 1'b0;
        enable_frame = 1'b0; uart_clk = 1'b0; data_valid = 1'b0;
        data_in = 8'h00; sync_char = 8'h80;
        enable_frame2 = 1'b0; data_valid2 = 1'b0; data_in2 = 7'h00; sync_char2 = 7'h40;
        hv = 1'b0; hd = 8'h00; fr = 1'b0; fr2 = 1'b0;

        // Reset: a tick and frame strobe while held in reset must be ignored.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_clk     = (i == 1);
            enable_frame = (i == 1);
            check_eq("rst_tx", tx, 1);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_sync_miss", sync_miss, 0);
            @(negedge clk);
        end
        uart_clk = 1'b0; enable_frame = 1'b0;
        rst_n = 1'b1; rst2_n = 1'b1;
        m_busy = 1'b0; m_pend = 1'b0; m_miss = 1'b0; m_elapsed = 0;

        // Idle line: data_ready only on tick cycles.
        ticks(3);

        // Frame strobe between ticks: sync starts on the next tick, 48 low / 60 busy ticks.
        obs_q.delete(); busy_ticks = 0; low_ticks = 0; miss_cycles = 0;
        fr = 1'b1; cyc(1'b0); cyc(1'b0); cyc(1'b0);
        ticks(70);
        check_eq("sync_low_ticks", low_ticks, 48);
        check_eq("sync_busy_ticks", busy_ticks, 60);
        check_eq("sync_high_ticks", busy_ticks - low_ticks, 12);
        check_eq("sync_no_miss", miss_cycles, 0);
        check_eq("sync_value", decode_at(first_low(0)), 8'h80);

        // Host byte 0xA5 accepted on the first tick.
        obs_q.delete();
        hv = 1'b1; hd = 8'hA5;
        ticks(65);
        s1 = first_low(0);
        check_eq("a5_start_tick", s1, 1);
        check_eq("a5_value", decode_at(s1), 8'hA5);
        check_eq("a5_stop_bit", (s1 >= 0) ? obs_q[s1 + 9 * OS + OS / 2] : -1, 1);

        // Frame and host byte on the same tick: sync first, host byte one tick after it ends.
        obs_q.delete();
        fr = 1'b1; hv = 1'b1; hd = 8'h55;
        ticks(130);
        s1 = first_low(0);
        s2 = first_low(s1 + CHAR_TICKS);
        check_eq("collide_first", decode_at(s1), 8'h80);
        check_eq("collide_second", decode_at(s2), 8'h55);
        check_eq("collide_gap", s2 - s1, CHAR_TICKS + 1);

        // Two strobes during one host character: one miss pulse, exactly one sync follows.
        obs_q.delete(); miss_cycles = 0;
        hv = 1'b1; hd = 8'($urandom);
        ticks(3);
        fr = 1'b1; cyc(1'b0);
        ticks(5);
        fr = 1'b1; cyc(1'b0);
        ticks(130);
        check_eq("miss_pulses", miss_cycles, 1);
        check_eq("miss_char_count", count_chars(), 2);
        s1 = first_low(0);
        check_eq("miss_sync_value", decode_at(first_low(s1 + CHAR_TICKS)), 8'h80);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            fr = ($urandom_range(0, 39) == 0);
            if (!hv && $urandom_range(0, 3) == 0) hv = 1'b1;
            hd = 8'($urandom);
            sc = 8'($urandom);
            cyc($urandom_range(0, 2) == 0);
        end
        hv = 1'b0; sc = 8'h80;
        ticks(130);

        // 7-bit, 2 stop bits, x4: 40-tick character, 28 ticks low for 0x40.
        busy2_ticks = 0; low2_ticks = 0; miss2_cycles = 0;
        fr2 = 1'b1;
        ticks(50);
        check_eq("cfg2_busy_ticks", busy2_ticks, 40);
        check_eq("cfg2_low_ticks", low2_ticks, 28);

        // Reset mid-DATA with a sync queued: line goes high at once, nothing resumes.
        fr2 = 1'b1; ticks(5);
        fr2 = 1'b1; cyc(1'b0);
        ticks(5);
        check_eq("cfg2_busy_before_rst", busy2, 1);
        check_eq("cfg2_tx_before_rst", tx2, 0);
        #2 rst2_n = 1'b0;
        #1;
        check_eq("cfg2_rst_tx", tx2, 1);
        check_eq("cfg2_rst_busy", busy2, 0);
        @(negedge clk);
        rst2_n = 1'b1;
        uart_clk = 1'b1; #1;
        check_eq("cfg2_ready_on_tick", data_ready2, 1);
        uart_clk = 1'b0; #1;
        check_eq("cfg2_ready_off_tick", data_ready2, 0);
        busy2_ticks = 0;
        ticks(20);
        check_eq("cfg2_no_recovery", busy2_ticks, 0);
        check_eq("cfg2_no_miss", miss2_cycles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
